// File: rtl/max_select_stream_pkg.sv
// Shared types and defaults for the max_select_stream engine.
// Provides the default element count/width, element/mask/index typedefs,
// the controller state encoding and a lowest-set-bit helper.
package max_select_stream_pkg;

   localparam int unsigned NDefault    = 8;
   localparam int unsigned WDefault    = 8;
   localparam int unsigned IdxWDefault = $clog2(NDefault);

   typedef logic [WDefault-1:0]    elem_t;
   typedef logic [NDefault-1:0]    mask_t;
   typedef logic [IdxWDefault-1:0] idx_t;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StEmit
   } state_e;

   // Index of the lowest set bit; 0 when the mask is empty.
   function automatic idx_t lowest_set(input mask_t mask);
      idx_t idx;
      idx = '0;
      for (int k = NDefault - 1; k >= 0; k--) begin
         if (mask[k]) idx = idx_t'(k);
      end
      return idx;
   endfunction

endpackage

// File: rtl/max_select_stream_if.sv
// Load/stream bundle for max_select_stream.
//   i_load_valid / o_load_ready : load handshake, i_data packed operands
//                                 (element k at [k*W +: W]), i_mode sort order
//   o_out_valid / i_out_ready   : output handshake carrying o_out_data,
//                                 o_out_idx and o_out_last
//   o_busy                      : a set is being scanned or emitted
// slave is the engine side, master the producer/consumer side.
interface max_select_stream_if
   import max_select_stream_pkg::*;
#(
   parameter int unsigned N    = NDefault,
   parameter int unsigned W    = WDefault,
   parameter int unsigned IDXW = $clog2(N)
);

   logic            i_load_valid;
   logic            o_load_ready;
   logic [N*W-1:0]  i_data;
   logic            i_mode;
   logic            o_out_valid;
   logic            i_out_ready;
   logic [W-1:0]    o_out_data;
   logic [IDXW-1:0] o_out_idx;
   logic            o_out_last;
   logic            o_busy;

   modport slave (
      input  i_load_valid,
      input  i_data,
      input  i_mode,
      input  i_out_ready,
      output o_load_ready,
      output o_out_valid,
      output o_out_data,
      output o_out_idx,
      output o_out_last,
      output o_busy
   );

   modport master (
      output i_load_valid,
      output i_data,
      output i_mode,
      output i_out_ready,
      input  o_load_ready,
      input  o_out_valid,
      input  o_out_data,
      input  o_out_idx,
      input  o_out_last,
      input  o_busy
   );

endinterface

// File: rtl/max_select_stream_bitplane_select.sv
// One bit-plane narrowing step (combinational).
//   i_plane : per-element bit of the current plane (already mode-adjusted)
//   i_chi   : current candidate mask
//   o_chi   : candidates that also have the plane bit set
//   o_hit   : at least one candidate has the plane bit set
module max_select_stream_bitplane_select #(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] i_plane,
   input  logic [N-1:0] i_chi,
   output logic [N-1:0] o_chi,
   output logic         o_hit
);

   assign o_chi = i_chi & i_plane;
   assign o_hit = |o_chi;

endmodule

// File: rtl/max_select_stream.sv
// Iterative bit-plane selection engine: loads N words of W bits, then streams
// them out max-first (i_mode=0) or min-first (i_mode=1) with source indices.
// Each pass narrows a candidate mask one bit plane per cycle, MSB to LSB; tied
// values are emitted lowest-index-first straight from the leftover mask.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus_io  : load/stream bundle (slave side), see max_select_stream_if
module max_select_stream
   import max_select_stream_pkg::*;
#(
   parameter int unsigned N = NDefault,
   parameter int unsigned W = WDefault
) (
   input logic                i_clk,
   input logic                i_rst_n,
   max_select_stream_if.slave bus_io
);

   localparam int unsigned IDXW = $clog2(N);
   localparam int unsigned BW   = (W > 1) ? $clog2(W) : 1;
   localparam logic [BW-1:0] BTop = BW'(W - 1);

   state_e                state_q, state_d;
   logic [N-1:0][W-1:0]   data_q, data_d;
   logic                  mode_q, mode_d;
   logic [N-1:0]          alive_q, alive_d;
   logic [N-1:0]          chi_q, chi_d;
   logic [BW-1:0]         b_q, b_d;
   logic                  out_valid_q, out_valid_d;
   logic [W-1:0]          out_data_q, out_data_d;
   logic [IDXW-1:0]       out_idx_q, out_idx_d;
   logic                  out_last_q, out_last_d;

   logic [N-1:0]          plane;
   logic [N-1:0]          chi_narrow;
   logic                  plane_hit;
   logic [N-1:0]          sel_oh;
   logic [N-1:0]          rest;

   function automatic logic [IDXW-1:0] first_set(input logic [N-1:0] mask);
      logic [IDXW-1:0] idx;
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (mask[k]) idx = IDXW'(k);
      end
      return idx;
   endfunction

   // Ascending order is a descending search over inverted planes.
   always_comb begin
      plane = '0;
      for (int k = 0; k < N; k++) begin
         plane[k] = data_q[k][b_q] ^ mode_q;
      end
   end

   max_select_stream_bitplane_select #(
      .N (N)
   ) u_bitplane_select (
      .i_plane (plane),
      .i_chi   (chi_q),
      .o_chi   (chi_narrow),
      .o_hit   (plane_hit)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      mode_d  = mode_q;
      alive_d = alive_q;
      chi_d   = chi_q;
      b_d     = b_q;

      // The registered index is always lowest_set(chi_q) while emitting.
      sel_oh            = '0;
      sel_oh[out_idx_q] = 1'b1;
      rest              = chi_q & ~sel_oh;

      unique case (state_q)
         StIdle: begin
            if (bus_io.i_load_valid) begin
               data_d  = bus_io.i_data;
               mode_d  = bus_io.i_mode;
               alive_d = '1;
               chi_d   = '1;
               b_d     = BTop;
               state_d = StScan;
            end
         end
         StScan: begin
            // No candidate has this bit: all remain tied on this plane.
            if (plane_hit) chi_d = chi_narrow;
            if (b_q == '0) begin
               state_d = StEmit;
            end else begin
               b_d = b_q - BW'(1);
            end
         end
         StEmit: begin
            if (out_valid_q && bus_io.i_out_ready) begin
               alive_d = alive_q & ~sel_oh;
               if (alive_d == '0) begin
                  chi_d   = '0;
                  state_d = StIdle;
               end else if (rest != '0) begin
                  chi_d = rest;
               end else begin
                  chi_d   = alive_d;
                  b_d     = BTop;
                  state_d = StScan;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Outputs are computed from next state so they are registered yet
      // valid in the same cycle the controller enters/stays in EMIT.
      out_valid_d = (state_d == StEmit);
      out_data_d  = '0;
      out_idx_d   = '0;
      out_last_d  = 1'b0;
      if (state_d == StEmit) begin
         out_idx_d  = first_set(chi_d);
         out_data_d = data_d[out_idx_d];
         out_last_d = ((alive_d & (alive_d - N'(1))) == '0);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         data_q      <= '0;
         mode_q      <= 1'b0;
         alive_q     <= '0;
         chi_q       <= '0;
         b_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         mode_q      <= mode_d;
         alive_q     <= alive_d;
         chi_q       <= chi_d;
         b_q         <= b_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
      end
   end

   assign bus_io.o_load_ready = (state_q == StIdle);
   assign bus_io.o_busy       = (state_q != StIdle);
   assign bus_io.o_out_valid  = out_valid_q;
   assign bus_io.o_out_data   = out_data_q;
   assign bus_io.o_out_idx    = out_idx_q;
   assign bus_io.o_out_last   = out_last_q;

endmodule

// File: tb/tb_max_select_stream.sv
// Directed self-checking bench for max_select_stream with N=4, W=4.
// Inputs change and outputs are sampled on the falling clock edge.
// "wait" counts falling edges from the one after the accepting edge (load or
// previous output handshake) until o_out_valid is seen: W for a fresh scan,
// 0 for a tied successor.
module tb_max_select_stream;

   localparam int unsigned N = 4;
   localparam int unsigned W = 4;

   logic clk;
   logic rst_n;
   int   n_compared;
   int   n_mismatched;

   max_select_stream_if #(.N(N), .W(W)) bus ();

   max_select_stream #(
      .N (N),
      .W (W)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus_io  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      if (obs !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Call at a falling edge; returns at the falling edge after acceptance.
   task automatic do_load(input string tag, input logic [15:0] d, input logic m);
      bus.i_load_valid = 1'b1;
      bus.i_data       = d;
      bus.i_mode       = m;
      check_eq({tag, "_ldrdy"}, 32'(bus.o_load_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.i_load_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag, input int exp_wait);
      int waited;
      waited = 0;
      while (!bus.o_out_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check_eq({tag, "_valid"}, 32'(bus.o_out_valid), 32'd1);
      check_eq({tag, "_wait"}, waited, exp_wait);
   endtask

   // Expects ready high; consumes the element and returns one falling edge later.
   task automatic expect_elem(input string tag, input int ed, input int ei, input logic el,
                              input int exp_wait);
      wait_valid(tag, exp_wait);
      check_eq({tag, "_data"}, 32'(bus.o_out_data), ed);
      check_eq({tag, "_idx"}, 32'(bus.o_out_idx), ei);
      check_eq({tag, "_last"}, 32'(bus.o_out_last), 32'(el));
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_ldrdy"}, 32'(bus.o_load_ready), 32'd1);
      check_eq({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
      check_eq({tag, "_valid"}, 32'(bus.o_out_valid), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_idle(tag);
      check_eq({tag, "_data"}, 32'(bus.o_out_data), 32'd0);
      check_eq({tag, "_idx"}, 32'(bus.o_out_idx), 32'd0);
      check_eq({tag, "_last"}, 32'(bus.o_out_last), 32'd0);
   endtask

   initial begin
      n_compared       = 0;
      n_mismatched     = 0;
      rst_n            = 1'b0;
      bus.i_load_valid = 1'b0;
      bus.i_data       = '0;
      bus.i_mode       = 1'b0;
      bus.i_out_ready  = 1'b0;

      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // {3,9,5,1} descending
      bus.i_out_ready = 1'b1;
      do_load("t1", 16'h1593, 1'b0);
      expect_elem("t1e0", 9, 1, 1'b0, 4);
      expect_elem("t1e1", 5, 2, 1'b0, 4);
      expect_elem("t1e2", 3, 0, 1'b0, 4);
      expect_elem("t1e3", 1, 3, 1'b1, 4);
      check_idle("t1end");

      // same data ascending
      do_load("t2", 16'h1593, 1'b1);
      expect_elem("t2e0", 1, 3, 1'b0, 4);
      expect_elem("t2e1", 3, 0, 1'b0, 4);
      expect_elem("t2e2", 5, 2, 1'b0, 4);
      expect_elem("t2e3", 9, 1, 1'b1, 4);
      check_idle("t2end");

      // ties {7,7,2,7}
      do_load("t3", 16'h7277, 1'b0);
      expect_elem("t3e0", 7, 0, 1'b0, 4);
      expect_elem("t3e1", 7, 1, 1'b0, 0);
      expect_elem("t3e2", 7, 3, 1'b0, 0);
      expect_elem("t3e3", 2, 2, 1'b1, 4);
      check_idle("t3end");

      // backpressure with stray load requests while busy
      bus.i_out_ready = 1'b0;
      do_load("t4", 16'h1593, 1'b0);
      wait_valid("t4first", 4);
      for (int i = 0; i < 10; i++) begin
         bus.i_load_valid = i[0];
         bus.i_data       = 16'hFFFF;
         @(negedge clk);
         check_eq("t4hold_valid", 32'(bus.o_out_valid), 32'd1);
         check_eq("t4hold_data", 32'(bus.o_out_data), 32'd9);
         check_eq("t4hold_idx", 32'(bus.o_out_idx), 32'd1);
         check_eq("t4hold_last", 32'(bus.o_out_last), 32'd0);
         check_eq("t4hold_ldrdy", 32'(bus.o_load_ready), 32'd0);
         check_eq("t4hold_busy", 32'(bus.o_busy), 32'd1);
      end
      bus.i_load_valid = 1'b0;
      bus.i_data       = '0;
      bus.i_out_ready  = 1'b1;
      expect_elem("t4e0", 9, 1, 1'b0, 0);
      expect_elem("t4e1", 5, 2, 1'b0, 4);
      expect_elem("t4e2", 3, 0, 1'b0, 4);
      expect_elem("t4e3", 1, 3, 1'b1, 4);
      check_idle("t4end");

      // all zeros: one scan, then pure tie drain
      do_load("t5", 16'h0000, 1'b0);
      expect_elem("t5e0", 0, 0, 1'b0, 4);
      expect_elem("t5e1", 0, 1, 1'b0, 0);
      expect_elem("t5e2", 0, 2, 1'b0, 0);
      expect_elem("t5e3", 0, 3, 1'b1, 0);
      check_idle("t5end");

      // async reset in the middle of a scan
      do_load("t6", 16'h1593, 1'b0);
      @(negedge clk);
      check_eq("t6scan_busy", 32'(bus.o_busy), 32'd1);
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("t6rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_eq("t6post_valid", 32'(bus.o_out_valid), 32'd0);
      end
      check_idle("t6post");
      do_load("t6b", 16'h480F, 1'b0);
      expect_elem("t6e0", 15, 0, 1'b0, 4);
      expect_elem("t6e1", 8, 2, 1'b0, 4);
      expect_elem("t6e2", 4, 3, 1'b0, 4);
      expect_elem("t6e3", 0, 1, 1'b1, 4);
      check_idle("t6end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
